// File: rtl/chan_select_pipe.sv
// N-channel operand selector: picks a primary channel and its partner, applies a
// per-transfer mode, and buffers results in a DEPTH-entry valid/ready output FIFO.
module chan_select_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH*WIDTH-1:0]     in_data,
  input  logic [NUM_CH-1:0]           in_valid,
  output logic [NUM_CH-1:0]           in_ready,
  input  logic [SEL_W-1:0]            sel,
  input  logic [1:0]                  mode,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NBYTES = WIDTH / 8;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_REV  = 2'd1,
    MODE_MAX  = 2'd2,
    MODE_OR   = 2'd3
  } mode_e;

  logic [WIDTH-1:0] ch [NUM_CH];
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [SEL_W-1:0] q_idx;
  mode_e            op;
  logic             two_op, full, accept, pop;
  logic [WIDTH-1:0] op_p, op_q, result;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign q_idx  = sel ^ SEL_W'(1);
  assign op     = mode_e'(mode);
  assign two_op = (op == MODE_MAX) || (op == MODE_OR);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign op_p   = ch[sel];
  assign op_q   = ch[q_idx];
  assign accept = !full && in_valid[sel] && (!two_op || in_valid[q_idx]);
  assign pop    = out_valid && out_ready;

  // Ready depends only on fullness and the input side, never on out_ready.
  always_comb begin
    in_ready = '0;
    if (rst_n && !full) begin
      in_ready[sel] = !two_op || in_valid[q_idx];
      if (two_op) begin
        in_ready[q_idx] = in_valid[sel];
      end
    end
  end

  always_comb begin
    result = op_p;
    unique case (op)
      MODE_PASS: result = op_p;
      MODE_REV: begin
        for (int unsigned k = 0; k < NBYTES; k++) begin
          result[k*8 +: 8] = op_p[(NBYTES-1-k)*8 +: 8];
        end
      end
      MODE_MAX:  result = (op_p >= op_q) ? op_p : op_q;
      MODE_OR:   result = op_p | op_q;
      default:   result = op_p;
    endcase
  end

  // out_data is a registered copy of the next head; it holds when the FIFO drains.
  always_comb begin
    wr_ptr_d   = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d    = count_q + CNT_W'(accept) - CNT_W'(pop);
    out_data_d = out_data_q;
    if (count_d != '0) begin
      out_data_d = (accept && (wr_ptr_q == rd_ptr_d)) ? result : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_chan_select_pipe.sv
// Self-checking bench for chan_select_pipe: constant vectors, directed corner
// sequences and random traffic checked against a queue-based reference model.
module tb_chan_select_pipe;

  localparam int W = 32;
  localparam int N = 4;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] ch [N];
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid, in_ready;
  logic [1:0]   sel, mode;
  logic [W-1:0] out_data;
  logic         out_valid, out_ready;
  logic [1:0]   count;

  always #5 clk = ~clk;
  assign in_data = {ch[3], ch[2], ch[1], ch[0]};

  chan_select_pipe #(.WIDTH(W), .NUM_CH(N), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  logic [W-1:0] mq[$];
  logic [W-1:0] m_last;
  int passed = 0;
  int total  = 0;

  function automatic logic [W-1:0] ref_result(input logic [W-1:0] p, input logic [W-1:0] q,
                                               input logic [1:0] m);
    logic [W-1:0] r;
    case (m)
      2'd0: r = p;
      2'd1: r = {<<8{p}};
      2'd2: r = (p >= q) ? p : q;
      default: r = p | q;
    endcase
    return r;
  endfunction

  function automatic logic [N-1:0] ref_ready();
    logic [N-1:0] r = '0;
    int pi = int'(sel);
    int qi = int'(sel) ^ 1;
    if (!rst_n || mq.size() == D) return '0;
    if (mode < 2) r[pi] = 1'b1;
    else begin
      r[pi] = in_valid[qi];
      r[qi] = in_valid[pi];
    end
    return r;
  endfunction

  function automatic bit ref_accept();
    int pi = int'(sel);
    int qi = int'(sel) ^ 1;
    return (mq.size() < D) && in_valid[pi] && (mode < 2 || in_valid[qi]);
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  // One clock: compare at negedge, advance the model at posedge, return at posedge+1.
  task automatic step();
    bit acc;
    logic [W-1:0] res;
    @(negedge clk);
    check("out_valid", W'(out_valid), W'(mq.size() != 0));
    check("out_data", out_data, (mq.size() != 0) ? mq[0] : m_last);
    check("count", W'(count), W'(mq.size()));
    check("in_ready", W'(in_ready), W'(ref_ready()));
    @(posedge clk);
    acc = ref_accept();
    res = ref_result(ch[sel], ch[sel ^ 2'd1], mode);
    if (mq.size() != 0 && out_ready) m_last = mq.pop_front();
    if (acc) mq.push_back(res);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0;
  endtask

  typedef struct {
    logic [1:0]     sel;
    logic [1:0]     mode;
    logic [N-1:0]   valid;
    logic [N*W-1:0] d;
    logic [N-1:0]   exp_ready;
    logic           exp_acc;
    logic [W-1:0]   exp_out;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'd2, 2'd0, 4'b0100, {32'h0, 32'hA5A5_0001, 32'h0, 32'h0}, 4'b0100, 1'b1, 32'hA5A5_0001};
    vecs[1] = '{2'd0, 2'd1, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h1122_3344}, 4'b0001, 1'b1, 32'h4433_2211};
    vecs[2] = '{2'd1, 2'd2, 4'b0011, {32'h0, 32'h0, 32'd5, 32'd9}, 4'b0011, 1'b1, 32'd9};
    vecs[3] = '{2'd1, 2'd2, 4'b0010, {32'h0, 32'h0, 32'd5, 32'd9}, 4'b0001, 1'b0, 32'h0};
    vecs[4] = '{2'd1, 2'd3, 4'b0011, {32'h0, 32'h0, 32'hF0, 32'h0F}, 4'b0011, 1'b1, 32'hFF};
    vecs[5] = '{2'd3, 2'd2, 4'b1100, {32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0}, 4'b1100, 1'b1, 32'h8000_0000};
    vecs[6] = '{2'd2, 2'd0, 4'b1011, {32'h1, 32'h2, 32'h3, 32'h4}, 4'b0100, 1'b0, 32'h0};
    vecs[7] = '{2'd0, 2'd3, 4'b0011, {32'h0, 32'h0, 32'h0F0F_0000, 32'hF0F0_00F0}, 4'b0011, 1'b1, 32'hFFFF_00F0};

    rst_n = 1'b0; in_valid = '1; sel = '0; mode = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) ch[i] = '0;
    model_reset();
    #12;
    check("rst_in_ready", W'(in_ready), '0);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_count", W'(count), '0);
    check("rst_out_data", out_data, '0);
    in_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      sel = vecs[v].sel; mode = vecs[v].mode; in_valid = vecs[v].valid;
      for (int i = 0; i < N; i++) ch[i] = vecs[v].d[i*W +: W];
      #1;
      check("vec_ready", W'(in_ready), W'(vecs[v].exp_ready));
      step();
      in_valid = '0;
      #1;
      check("vec_valid", W'(out_valid), W'(vecs[v].exp_acc));
      if (vecs[v].exp_acc) check("vec_data", out_data, vecs[v].exp_out);
      step();
    end

    // Backpressure: three pushes into a two-entry buffer.
    out_ready = 1'b0; sel = 2'd0; mode = 2'd0; in_valid = 4'b0001;
    ch[0] = 32'hDEAD_0001; step();
    ch[0] = 32'hDEAD_0002; step();
    ch[0] = 32'hDEAD_0003;
    #1;
    check("full_count", W'(count), W'(2));
    check("full_ready", W'(in_ready), '0);
    step();
    out_ready = 1'b1;
    step();
    step();
    in_valid = '0;
    step();
    step();
    check("drain_count", W'(count), '0);

    out_ready = 1'b1; mode = 2'd0;
    for (int i = 0; i < 16; i++) begin
      sel = 2'(i % 4);
      in_valid = 4'b0001 << (i % 4);
      ch[i % 4] = 32'h5000_0000 + 32'(i);
      step();
    end
    in_valid = '0;
    step(); step();

    // Mid-operation asynchronous reset with a full buffer.
    out_ready = 1'b0; sel = 2'd0; mode = 2'd0; in_valid = 4'b0001;
    ch[0] = 32'hCAFE_0001; step();
    ch[0] = 32'hCAFE_0002; step();
    in_valid = '0; step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", W'(out_valid), '0);
    check("mid_rst_count", W'(count), '0);
    check("mid_rst_ready", W'(in_ready), '0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    out_ready = 1'b1;
    step(); step();
    ch[0] = 32'hBEEF_0042; in_valid = 4'b0001; step();
    in_valid = '0; step(); step();

    for (int i = 0; i < 400; i++) begin
      sel = 2'($urandom_range(0, 3));
      mode = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom);
      for (int c = 0; c < N; c++) ch[c] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
